fdiv16: RTL and testbench

- Iterative IEEE-754 half-precision divider computing result = x / y.
- Sits beside the fp16 FMA datapath and covers the inverse operation of its multiply path.
- Uses the same operand format, roundmode encoding and flag semantics as the FMA, with divide-by-zero (DZ) added to the flag vector.
- Multi-cycle: restoring radix-2 mantissa divide behind a valid/ready handshake on both input and output.

---
 rtl/fp16_pkg.sv | 105 ++++++++++
 rtl/fp16_round.sv | 111 +++++++++++
 rtl/fdiv16.sv | 229 ++++++++++++++++++++++
 tb/tb_fdiv16.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// fp16_pkg: shared definitions for the half-precision arithmetic blocks
// (divider and FMA). Holds field widths, special encodings, flag bit
// positions, the roundmode encoding, the divider FSM states and small
// operand-classification helpers.
package fp16_pkg;

    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int BIAS   = 15;

    localparam logic [15:0] FP16_QNAN    = 16'h7E00;
    localparam logic [15:0] FP16_INF     = 16'h7C00;
    localparam logic [15:0] FP16_MAXNORM = 16'h7BFF;

    // Flag vector layout: {NV, DZ, OF, UF, NX}
    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_NV = 4;

    typedef enum logic [1:0] {
        RM_RZ  = 2'b00,
        RM_RNE = 2'b01,
        RM_RDN = 2'b10,
        RM_RUP = 2'b11
    } roundmode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNPACK = 3'd1,
        ST_ITER   = 3'd2,
        ST_ROUND  = 3'd3,
        ST_DONE   = 3'd4
    } fdiv_state_e;

    typedef enum logic [2:0] {
        FP_ZERO = 3'd0,
        FP_SUB  = 3'd1,
        FP_NORM = 3'd2,
        FP_INF  = 3'd3,
        FP_QNAN = 3'd4,
        FP_SNAN = 3'd5
    } fp_class_e;

    // Significand with explicit hidden bit, and unbiased-by-field exponent
    // (exponent field value, or 1-lzc for a normalised subnormal).
    typedef struct packed {
        logic [10:0]        man;
        logic signed [7:0]  exp;
    } fp_unpacked_t;

    // Leading-zero count of an 11-bit vector (returns 11 for all zeros).
    function automatic logic [3:0] lzc11(input logic [10:0] v);
        logic [3:0] n;
        logic       found;
        n     = 4'd0;
        found = 1'b0;
        for (int i = 10; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) begin
                    found = 1'b1;
                end else begin
                    n = n + 4'd1;
                end
            end else begin
                found = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic fp_class_e fp16_class(input logic [15:0] v);
        fp_class_e c;
        if (v[14:10] == 5'd0) begin
            c = (v[9:0] == 10'd0) ? FP_ZERO : FP_SUB;
        end else if (v[14:10] == 5'd31) begin
            if (v[9:0] == 10'd0) begin
                c = FP_INF;
            end else begin
                c = v[9] ? FP_QNAN : FP_SNAN;
            end
        end else begin
            c = FP_NORM;
        end
        return c;
    endfunction

    // Subnormals are shifted left until the hidden-bit position is set;
    // the exponent drops by the same amount starting from 1.
    function automatic fp_unpacked_t fp16_unpack(input logic [15:0] v);
        fp_unpacked_t u;
        logic [3:0]   lz;
        lz = lzc11({1'b0, v[9:0]});
        if (v[14:10] == 5'd0) begin
            u.man = {1'b0, v[9:0]} << lz;
            u.exp = 8'sd1 - $signed({4'd0, lz});
        end else begin
            u.man = {1'b1, v[9:0]};
            u.exp = $signed({3'd0, v[14:10]});
        end
        return u;
    endfunction

endpackage

// File: rtl/fp16_round.sv
// fp16_round: combinational denormalise / round / overflow / flag stage.
// Takes a quotient (or product) significand of the form 1.f[9:0] g r with
// a biased exponent that may be below 1, and produces the final fp16
// encoding plus {NV=0, DZ=0, OF, UF, NX}.
//   sign_i    result sign
//   exp_i     biased exponent before rounding (8-bit signed)
//   quo_i     13-bit significand: [12] integer, [11:2] fraction, [1] guard, [0] round
//   sticky_i  OR of all bits below the round bit
//   rm_i      rounding mode
//   result_o  rounded fp16 value
//   flags_o   exception flags
module fp16_round
    import fp16_pkg::*;
(
    input  logic               sign_i,
    input  logic signed [7:0]  exp_i,
    input  logic [12:0]        quo_i,
    input  logic               sticky_i,
    input  roundmode_e         rm_i,
    output logic [15:0]        result_o,
    output logic [4:0]         flags_o
);

    logic               tiny_s;
    logic signed [7:0]  shamt_s;
    logic [3:0]         sh4_s;
    logic [12:0]        q_den_s;
    logic [12:0]        lost_s;
    logic               st_den_s;
    logic signed [7:0]  exp_den_s;
    logic               guard_s;
    logic               rbit_s;
    logic               inexact_s;
    logic               inc_s;
    logic [11:0]        sum_s;
    logic signed [7:0]  exp_rnd_s;
    logic [9:0]         frac_s;
    logic               ovf_inf_s;

    // Denormalise tiny results, then round and encode
    always_comb begin
        tiny_s    = (exp_i < 8'sd1);
        shamt_s   = 8'sd1 - exp_i;
        sh4_s     = 4'd0;
        lost_s    = 13'd0;
        q_den_s   = quo_i;
        st_den_s  = sticky_i;
        exp_den_s = exp_i;

        if (tiny_s) begin
            exp_den_s = 8'sd0;
            if (shamt_s >= 8'sd14) begin
                q_den_s  = 13'd0;
                st_den_s = sticky_i | (|quo_i);
            end else begin
                sh4_s    = shamt_s[3:0];
                q_den_s  = quo_i >> sh4_s;
                lost_s   = quo_i & ~(13'h1FFF << sh4_s);
                st_den_s = sticky_i | (|lost_s);
            end
        end else begin
            exp_den_s = exp_i;
        end

        guard_s   = q_den_s[1];
        rbit_s    = q_den_s[0];
        inexact_s = guard_s | rbit_s | st_den_s;

        case (rm_i)
            RM_RZ:   inc_s = 1'b0;
            RM_RNE:  inc_s = guard_s & (rbit_s | st_den_s | q_den_s[2]);
            RM_RDN:  inc_s = sign_i & inexact_s;
            RM_RUP:  inc_s = ~sign_i & inexact_s;
            default: inc_s = 1'b0;
        endcase

        sum_s = {1'b0, q_den_s[12:2]} + {11'd0, inc_s};

        // A subnormal that rounds into bit 10 becomes the minimum normal.
        if (exp_den_s == 8'sd0) begin
            exp_rnd_s = $signed({7'd0, sum_s[10]});
            frac_s    = sum_s[9:0];
        end else if (sum_s[11]) begin
            exp_rnd_s = exp_den_s + 8'sd1;
            frac_s    = sum_s[10:1];
        end else begin
            exp_rnd_s = exp_den_s;
            frac_s    = sum_s[9:0];
        end

        case (rm_i)
            RM_RZ:   ovf_inf_s = 1'b0;
            RM_RNE:  ovf_inf_s = 1'b1;
            RM_RDN:  ovf_inf_s = sign_i;
            RM_RUP:  ovf_inf_s = ~sign_i;
            default: ovf_inf_s = 1'b1;
        endcase

        flags_o = 5'b00000;
        if (exp_rnd_s >= 8'sd31) begin
            result_o         = ovf_inf_s ? {sign_i, FP16_INF[14:0]} : {sign_i, FP16_MAXNORM[14:0]};
            flags_o[FLAG_OF] = 1'b1;
            flags_o[FLAG_NX] = 1'b1;
        end else begin
            result_o         = {sign_i, exp_rnd_s[4:0], frac_s};
            flags_o[FLAG_NX] = inexact_s;
            flags_o[FLAG_UF] = tiny_s & inexact_s;
        end
    end

endmodule

// File: rtl/fdiv16.sv
// fdiv16: iterative IEEE-754 half-precision divider, result = x / y.
// Restoring radix-2 mantissa divide, one quotient bit per cycle, behind
// valid/ready handshakes on input and output.
//   clk, reset_n          clock, synchronous active-low reset
//   in_valid / in_ready   operand handshake (ready only while idle)
//   x, y, roundmode       dividend, divisor, rounding mode
//   out_valid / out_ready result handshake
//   result, flags         quotient and {NV, DZ, OF, UF, NX}
module fdiv16
    import fp16_pkg::*;
#(
    parameter int unsigned ITERS     = 13,
    parameter bit          FIXED_LAT = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [1:0]  roundmode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic [4:0]  flags
);

    fdiv_state_e        state_q, state_d;
    logic [15:0]        x_q, x_d, y_q, y_d;
    roundmode_e         rm_q, rm_d;
    logic               sign_q, sign_d;
    logic signed [7:0]  exp_q, exp_d;
    logic [10:0]        my_q, my_d;
    logic [11:0]        rem_q, rem_d;
    logic [12:0]        quo_q, quo_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               spec_q, spec_d;
    logic [15:0]        spec_res_q, spec_res_d;
    logic [4:0]         spec_flg_q, spec_flg_d;
    logic [15:0]        result_q, result_d;
    logic [4:0]         flags_q, flags_d;

    fp_class_e          cls_x_s, cls_y_s;
    fp_unpacked_t       ux_s, uy_s;
    logic signed [7:0]  ex_s, ey_s, exp_raw_s, exp_init_s;
    logic [11:0]        rem_init_s;
    logic               sign_s, x_nan_s, y_nan_s;
    logic               spec_hit_s;
    logic [15:0]        spec_res_s;
    logic [4:0]         spec_flg_s;
    logic               rem_ge_s;
    logic [11:0]        rem_sub_s;
    logic [15:0]        rnd_res_s;
    logic [4:0]         rnd_flg_s;

    // Operand decode: classification, normalisation and special-case result
    always_comb begin
        cls_x_s = fp16_class(x_q);
        cls_y_s = fp16_class(y_q);
        ux_s    = fp16_unpack(x_q);
        uy_s    = fp16_unpack(y_q);
        ex_s    = ux_s.exp;
        ey_s    = uy_s.exp;
        sign_s  = x_q[15] ^ y_q[15];

        exp_raw_s = ex_s - ey_s + 8'sd15;
        // Pre-scaling the dividend keeps the quotient in [1,2).
        if (ux_s.man < uy_s.man) begin
            rem_init_s = {ux_s.man, 1'b0};
            exp_init_s = exp_raw_s - 8'sd1;
        end else begin
            rem_init_s = {1'b0, ux_s.man};
            exp_init_s = exp_raw_s;
        end

        x_nan_s    = (cls_x_s == FP_QNAN) || (cls_x_s == FP_SNAN);
        y_nan_s    = (cls_y_s == FP_QNAN) || (cls_y_s == FP_SNAN);
        spec_hit_s = 1'b1;
        spec_res_s = FP16_QNAN;
        spec_flg_s = 5'b00000;
        if (x_nan_s || y_nan_s) begin
            spec_flg_s[FLAG_NV] = (cls_x_s == FP_SNAN) || (cls_y_s == FP_SNAN);
        end else if (((cls_x_s == FP_ZERO) && (cls_y_s == FP_ZERO)) ||
                     ((cls_x_s == FP_INF) && (cls_y_s == FP_INF))) begin
            spec_flg_s[FLAG_NV] = 1'b1;
        end else if (cls_y_s == FP_ZERO) begin
            spec_res_s          = {sign_s, FP16_INF[14:0]};
            spec_flg_s[FLAG_DZ] = 1'b1;
        end else if (cls_x_s == FP_INF) begin
            spec_res_s = {sign_s, FP16_INF[14:0]};
        end else if ((cls_y_s == FP_INF) || (cls_x_s == FP_ZERO)) begin
            spec_res_s = {sign_s, 15'd0};
        end else begin
            spec_hit_s = 1'b0;
        end
    end

    // One restoring divide step on the current partial remainder
    always_comb begin
        rem_ge_s  = (rem_q >= {1'b0, my_q});
        rem_sub_s = rem_ge_s ? (rem_q - {1'b0, my_q}) : rem_q;
    end

    fp16_round u_round (
        .sign_i   (sign_q),
        .exp_i    (exp_q),
        .quo_i    (quo_q),
        .sticky_i (rem_q != 12'd0),
        .rm_i     (rm_q),
        .result_o (rnd_res_s),
        .flags_o  (rnd_flg_s)
    );

    // FSM next-state and datapath next values
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        rm_d       = rm_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        my_d       = my_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        spec_flg_d = spec_flg_q;
        result_d   = result_q;
        flags_d    = flags_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    x_d     = x;
                    y_d     = y;
                    rm_d    = roundmode_e'(roundmode);
                    state_d = ST_UNPACK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_UNPACK: begin
                sign_d     = sign_s;
                exp_d      = exp_init_s;
                my_d       = uy_s.man;
                rem_d      = rem_init_s;
                quo_d      = 13'd0;
                cnt_d      = 4'd0;
                spec_d     = spec_hit_s;
                spec_res_d = spec_res_s;
                spec_flg_d = spec_flg_s;
                if (spec_hit_s && !FIXED_LAT) begin
                    state_d = ST_ROUND;
                end else begin
                    state_d = ST_ITER;
                end
            end
            ST_ITER: begin
                rem_d = rem_sub_s << 1;
                quo_d = {quo_q[11:0], rem_ge_s};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(ITERS - 1)) begin
                    state_d = ST_ROUND;
                end else begin
                    state_d = ST_ITER;
                end
            end
            ST_ROUND: begin
                result_d = spec_q ? spec_res_q : rnd_res_s;
                flags_d  = spec_q ? spec_flg_q : rnd_flg_s;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            x_q        <= 16'h0000;
            y_q        <= 16'h0000;
            rm_q       <= RM_RZ;
            sign_q     <= 1'b0;
            exp_q      <= 8'sd0;
            my_q       <= 11'd0;
            rem_q      <= 12'd0;
            quo_q      <= 13'd0;
            cnt_q      <= 4'd0;
            spec_q     <= 1'b0;
            spec_res_q <= 16'h0000;
            spec_flg_q <= 5'b00000;
            result_q   <= 16'h0000;
            flags_q    <= 5'b00000;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            rm_q       <= rm_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            my_q       <= my_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            spec_flg_q <= spec_flg_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fdiv16.sv
// tb_fdiv16: scoreboard bench for fdiv16. Directed vectors carry constant
// expectations; random vectors are checked against an exact rational
// reference built from integer significands and power-of-two scaling.
module tb_fdiv16;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x_in;
    logic [15:0] y_in;
    logic [1:0]  rm_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [4:0]  flags;

    int n_checks = 0;
    int n_errors = 0;
    bit bp_en    = 1'b0;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [1:0]  rm;
        logic [15:0] res;
        logic [4:0]  flg;
    } exp_t;

    exp_t sb_q[$];

    fdiv16 dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x_in),
        .y         (y_in),
        .roundmode (rm_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Exact reference: quotient = ma/mb * 2^(ea-eb), rounded onto the fp16 grid.
    function automatic logic [20:0] ref_div(input logic [15:0] a, input logic [15:0] b, input logic [1:0] rm);
        bit s, a_nan, b_nan, a_snan, b_snan, a_zero, b_zero, a_inf, b_inf;
        longint ma, mb, num, den, k, rem;
        int ea, eb, t, lga, lgb, p, sq, sh, expf;
        bit tiny, inexact, inc, to_inf;
        logic [15:0] r;
        s      = a[15] ^ b[15];
        a_nan  = (a[14:10] == 5'd31) && (a[9:0] != 10'd0);
        b_nan  = (b[14:10] == 5'd31) && (b[9:0] != 10'd0);
        a_snan = a_nan && !a[9];
        b_snan = b_nan && !b[9];
        a_inf  = (a[14:10] == 5'd31) && (a[9:0] == 10'd0);
        b_inf  = (b[14:10] == 5'd31) && (b[9:0] == 10'd0);
        a_zero = (a[14:0] == 15'd0);
        b_zero = (b[14:0] == 15'd0);
        if (a_nan || b_nan) return {16'h7E00, (a_snan || b_snan) ? 5'b10000 : 5'b00000};
        if ((a_zero && b_zero) || (a_inf && b_inf)) return {16'h7E00, 5'b10000};
        if (b_zero) return {s, 15'h7C00, 5'b01000};
        if (a_inf) return {s, 15'h7C00, 5'b00000};
        if (b_inf || a_zero) return {s, 15'h0000, 5'b00000};
        ma = (a[14:10] == 5'd0) ? longint'(a[9:0]) : longint'(a[9:0]) + 1024;
        mb = (b[14:10] == 5'd0) ? longint'(b[9:0]) : longint'(b[9:0]) + 1024;
        ea = ((a[14:10] == 5'd0) ? 1 : int'(a[14:10])) - 25;
        eb = ((b[14:10] == 5'd0) ? 1 : int'(b[14:10])) - 25;
        t  = ea - eb;
        lga = 0;
        lgb = 0;
        for (int i = 0; i < 11; i++) begin
            if (((ma >> i) & 1) != 0) lga = i;
            if (((mb >> i) & 1) != 0) lgb = i;
        end
        p = lga - lgb;
        if ((ma << lgb) < (mb << lga)) p = p - 1;
        p    = p + t;
        tiny = (p < -14);
        sq   = (tiny ? -14 : p) - 10;
        sh   = t - sq;
        if (sh >= 0) begin
            num = ma << sh;
            den = mb;
        end else begin
            num = ma;
            den = mb << (-sh);
        end
        k       = num / den;
        rem     = num % den;
        inexact = (rem != 0);
        case (rm)
            2'b00:   inc = 1'b0;
            2'b01:   inc = (2 * rem > den) || ((2 * rem == den) && (k % 2 == 1));
            2'b10:   inc = inexact && s;
            default: inc = inexact && !s;
        endcase
        if (inc) k = k + 1;
        if (k == 2048) begin
            k  = 1024;
            sq = sq + 1;
        end
        expf = (k >= 1024) ? sq + 25 : 0;
        if (expf >= 31) begin
            to_inf = (rm == 2'b01) || (rm == 2'b11 && !s) || (rm == 2'b10 && s);
            r = to_inf ? {s, 15'h7C00} : {s, 15'h7BFF};
            return {r, 5'b00101};
        end
        r = {s, 5'(expf), 10'((k >= 1024) ? k - 1024 : k)};
        return {r, 3'b000, tiny && inexact, inexact};
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] v;
        int          sel;
        v   = 16'($urandom);
        sel = $urandom_range(0, 11);
        case (sel)
            0:       v[14:0]  = 15'd0;
            1:       v[14:10] = 5'd0;
            2:       v[14:10] = 5'd31;
            default: v[14:10] = 5'($urandom_range(1, 30));
        endcase
        return v;
    endfunction

    // Issue one operation; the expectation is queued on the accepting edge.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] rm,
                         input bit push, input logic [15:0] eres, input logic [4:0] eflg);
        bit   acc;
        exp_t e;
        x_in     = a;
        y_in     = b;
        rm_in    = rm;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int n = 0; n < 400 && !acc; n++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
        end
        if (!acc) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: in_ready never rose, got 0, expected 1");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (push) begin
                e.x = a; e.y = b; e.rm = rm; e.res = eres; e.flg = eflg;
                sb_q.push_back(e);
            end
            #2;
            in_valid = 1'b0;
        end
    endtask

    task automatic do_ref_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] rm);
        logic [20:0] r;
        r = ref_div(a, b, rm);
        do_op(a, b, rm, 1'b1, r[20:5], r[4:0]);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", 32'(sb_q.size()), 32'd0);
    endtask

    // Monitor: compare every output handshake against the queue head
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got %h, expected no output", result);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("result %h/%h rm%0d", e.x, e.y, e.rm), 32'(result), 32'(e.res));
                check($sformatf("flags %h/%h rm%0d", e.x, e.y, e.rm), 32'(flags), 32'(e.flg));
            end
        end
    end

    // Random output backpressure when enabled
    always @(posedge clk) begin
        if (bp_en) begin
            #2;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x_in      = 16'h0000;
        y_in      = 16'h0000;
        rm_in     = 2'b01;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", 32'(result), 32'h0000);
        check("reset flags", 32'(flags), 32'd0);
        #1;

        // 2 / 1 with latency and in_ready monitoring
        do_op(16'h4000, 16'h3C00, 2'b01, 1'b1, 16'h4000, 5'b00000);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!out_valid) check("busy in_ready", 32'(in_ready), 32'd0);
        end
        check("latency", 32'(cyc), 32'd15);
        drain();

        do_op(16'h3C00, 16'h4200, 2'b01, 1'b1, 16'h3555, 5'b00001);
        do_op(16'h3C00, 16'h4200, 2'b00, 1'b1, 16'h3555, 5'b00001);
        do_op(16'h3C00, 16'h4200, 2'b11, 1'b1, 16'h3556, 5'b00001);
        do_op(16'h3C00, 16'h0000, 2'b01, 1'b1, 16'h7C00, 5'b01000);
        do_op(16'h0000, 16'h0000, 2'b01, 1'b1, 16'h7E00, 5'b10000);
        do_op(16'h7D00, 16'h3C00, 2'b01, 1'b1, 16'h7E00, 5'b10000);
        do_op(16'h7E00, 16'h3C00, 2'b01, 1'b1, 16'h7E00, 5'b00000);
        do_op(16'h7BFF, 16'h3800, 2'b01, 1'b1, 16'h7C00, 5'b00101);
        do_op(16'h7BFF, 16'h3800, 2'b00, 1'b1, 16'h7BFF, 5'b00101);
        do_op(16'hFBFF, 16'h3800, 2'b11, 1'b1, 16'hFBFF, 5'b00101);
        do_op(16'h0400, 16'h4000, 2'b01, 1'b1, 16'h0200, 5'b00000);
        do_op(16'h0001, 16'h4000, 2'b01, 1'b1, 16'h0000, 5'b00011);
        do_op(16'h0001, 16'h4000, 2'b11, 1'b1, 16'h0001, 5'b00011);
        do_op(16'h7C00, 16'hBC00, 2'b01, 1'b1, 16'hFC00, 5'b00000);
        do_op(16'h3C00, 16'hFC00, 2'b01, 1'b1, 16'h8000, 5'b00000);
        drain();

        // Random operands with random backpressure
        bp_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            do_ref_op(rand_op(), rand_op(), 2'($urandom_range(0, 3)));
        end
        drain();
        bp_en = 1'b0;
        @(posedge clk);
        #2;

        // Stall in DONE: outputs must hold
        out_ready = 1'b0;
        do_op(16'h4000, 16'h3C00, 2'b01, 1'b1, 16'h4000, 5'b00000);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall out_valid", 32'(out_valid), 32'd1);
            check("stall result", 32'(result), 32'h4000);
            check("stall flags", 32'(flags), 32'd0);
            check("stall in_ready", 32'(in_ready), 32'd0);
        end
        #1;
        out_ready = 1'b1;
        drain();

        // Reset while iterating discards the operation
        do_op(16'h3C00, 16'h4200, 2'b01, 1'b0, 16'h0000, 5'b00000);
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd1);
        #1;
        reset_n = 1'b1;
        do_op(16'h4000, 16'h3C00, 2'b01, 1'b1, 16'h4000, 5'b00000);
        drain();

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
